// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative multiply/divide unit
// that stalls upstream for DATA_W+1 cycles and feeds registered results to MEM.
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              e_valid_i,
    input  logic [3:0]        e_alu_op_i,
    input  logic [DATA_W-1:0] e_op_a_i,
    input  logic [DATA_W-1:0] e_op_b_i,
    input  logic [DATA_W-1:0] e_store_val_i,
    input  logic [ADDR_W-1:0] e_des_r_i,
    input  logic              e_write_reg_i,
    input  logic              e_mem_to_reg_i,
    input  logic              e_write_mem_i,
    output logic              stall_o,
    output logic              m_write_reg_o,
    output logic              m_mem_to_reg_o,
    output logic              m_write_mem_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] write_mem_val_o,
    output logic [ADDR_W-1:0] m_des_r_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt_p1;
    logic [3:0]          r_op_p0;
    logic                r_wr_p0, r_mtr_p0, r_wm_p0;
    logic [ADDR_W-1:0]   r_des_p0;
    logic [DATA_W-1:0]   r_st_p0;
    logic [DATA_W-1:0]   r_acc_p1;
    logic [DATA_W-1:0]   r_x_p1;
    logic [DATA_W-1:0]   r_y_p1;
    logic                w_is_multi;
    logic [DATA_W-1:0]   w_multi_res;

    function automatic logic [DATA_W-1:0] alu_single(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return (sa < sb) ? DATA_W'(1) : '0;
            4'd7:    return (a < b) ? DATA_W'(1) : '0;
            4'd8:    return a << b[4:0];
            4'd9:    return a >> b[4:0];
            4'd10:   return sa >>> b[4:0];
            4'd11:   return b << 16;
            4'd15:   return b;
            default: return '0;
        endcase
    endfunction

    // One restoring-divide step: returns {remainder, quotient/dividend}.
    function automatic logic [2*DATA_W-1:0] div_step(
        input logic [DATA_W-1:0] rem,
        input logic [DATA_W-1:0] quo,
        input logic [DATA_W-1:0] dvs
    );
        logic [DATA_W:0] sh;
        logic [DATA_W:0] diff;
        sh   = {rem, quo[DATA_W-1]};
        diff = sh - {1'b0, dvs};
        if (!diff[DATA_W])
            return {diff[DATA_W-1:0], quo[DATA_W-2:0], 1'b1};
        else
            return {sh[DATA_W-1:0], quo[DATA_W-2:0], 1'b0};
    endfunction

    assign w_is_multi  = (e_alu_op_i == 4'd12) || (e_alu_op_i == 4'd13) ||
                         (e_alu_op_i == 4'd14);
    assign w_multi_res = (r_op_p0 == 4'd13) ? r_x_p1 : r_acc_p1;
    assign stall_o     = rst_n && (((r_state == IDLE) && e_valid_i && w_is_multi) ||
                                   (r_state == BUSY));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (e_valid_i && w_is_multi) w_state_nxt = BUSY;
            BUSY:    if (r_cnt_p1 == CNT_W'(DATA_W - 1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_p1        <= '0;
            r_op_p0         <= '0;
            r_wr_p0         <= 1'b0;
            r_mtr_p0        <= 1'b0;
            r_wm_p0         <= 1'b0;
            r_des_p0        <= '0;
            r_st_p0         <= '0;
            r_acc_p1        <= '0;
            r_x_p1          <= '0;
            r_y_p1          <= '0;
            m_write_reg_o   <= 1'b0;
            m_mem_to_reg_o  <= 1'b0;
            m_write_mem_o   <= 1'b0;
            alu_result_o    <= '0;
            write_mem_val_o <= '0;
            m_des_r_o       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (e_valid_i && w_is_multi) begin
                        r_op_p0  <= e_alu_op_i;
                        r_wr_p0  <= e_write_reg_i;
                        r_mtr_p0 <= e_mem_to_reg_i;
                        r_wm_p0  <= e_write_mem_i;
                        r_des_p0 <= e_des_r_i;
                        r_st_p0  <= e_store_val_i;
                        r_cnt_p1 <= '0;
                        r_acc_p1 <= '0;
                        r_x_p1   <= e_op_a_i;
                        r_y_p1   <= e_op_b_i;
                    end
                    if (e_valid_i && !w_is_multi) begin
                        m_write_reg_o   <= e_write_reg_i;
                        m_mem_to_reg_o  <= e_mem_to_reg_i;
                        m_write_mem_o   <= e_write_mem_i;
                        alu_result_o    <= alu_single(e_alu_op_i, e_op_a_i, e_op_b_i);
                        write_mem_val_o <= e_store_val_i;
                        m_des_r_o       <= e_des_r_i;
                    end else begin
                        m_write_reg_o  <= 1'b0;
                        m_mem_to_reg_o <= 1'b0;
                        m_write_mem_o  <= 1'b0;
                    end
                end
                BUSY: begin
                    // MUL: acc += x when y's LSB is set; x walks left, y walks right.
                    if (r_op_p0 == 4'd12) begin
                        r_acc_p1 <= r_acc_p1 + (r_y_p1[0] ? r_x_p1 : '0);
                        r_x_p1   <= r_x_p1 << 1;
                        r_y_p1   <= r_y_p1 >> 1;
                    end else begin
                        {r_acc_p1, r_x_p1} <= div_step(r_acc_p1, r_x_p1, r_y_p1);
                    end
                    r_cnt_p1       <= r_cnt_p1 + CNT_W'(1);
                    m_write_reg_o  <= 1'b0;
                    m_mem_to_reg_o <= 1'b0;
                    m_write_mem_o  <= 1'b0;
                end
                DONE: begin
                    m_write_reg_o   <= r_wr_p0;
                    m_mem_to_reg_o  <= r_mtr_p0;
                    m_write_mem_o   <= r_wm_p0;
                    alu_result_o    <= w_multi_res;
                    write_mem_val_o <= r_st_p0;
                    m_des_r_o       <= r_des_p0;
                end
                default: begin
                    m_write_reg_o  <= 1'b0;
                    m_mem_to_reg_o <= 1'b0;
                    m_write_mem_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          e_valid_i;
    logic [3:0]    e_alu_op_i;
    logic [DW-1:0] e_op_a_i;
    logic [DW-1:0] e_op_b_i;
    logic [DW-1:0] e_store_val_i;
    logic [AW-1:0] e_des_r_i;
    logic          e_write_reg_i;
    logic          e_mem_to_reg_i;
    logic          e_write_mem_i;
    logic          stall_o;
    logic          m_write_reg_o;
    logic          m_mem_to_reg_o;
    logic          m_write_mem_o;
    logic [DW-1:0] alu_result_o;
    logic [DW-1:0] write_mem_val_o;
    logic [AW-1:0] m_des_r_o;

    ex_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .e_valid_i(e_valid_i), .e_alu_op_i(e_alu_op_i),
        .e_op_a_i(e_op_a_i), .e_op_b_i(e_op_b_i), .e_store_val_i(e_store_val_i),
        .e_des_r_i(e_des_r_i), .e_write_reg_i(e_write_reg_i),
        .e_mem_to_reg_i(e_mem_to_reg_i), .e_write_mem_i(e_write_mem_i),
        .stall_o(stall_o), .m_write_reg_o(m_write_reg_o),
        .m_mem_to_reg_o(m_mem_to_reg_o), .m_write_mem_o(m_write_mem_o),
        .alu_result_o(alu_result_o), .write_mem_val_o(write_mem_val_o),
        .m_des_r_o(m_des_r_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model of the data outputs, which hold across bubbles.
    logic [31:0] m_alu = '0;
    logic [31:0] m_st  = '0;
    logic [4:0]  m_des = '0;

    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] wide;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return a << b[4:0];
            4'd9:  return a >> b[4:0];
            4'd10: begin wide = {{32{a[31]}}, a} >> b[4:0]; return wide[31:0]; end
            4'd11: return {b[15:0], 16'h0000};
            4'd12: begin wide = {32'd0, a} * {32'd0, b}; return wide[31:0]; end
            4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14: return (b == 0) ? a : a % b;
            default: return b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] st, input logic [4:0] des,
                         input logic wr, input logic mtr, input logic wm);
        e_valid_i      = v;
        e_alu_op_i     = op;
        e_op_a_i       = a;
        e_op_b_i       = b;
        e_store_val_i  = st;
        e_des_r_i      = des;
        e_write_reg_i  = wr;
        e_mem_to_reg_i = mtr;
        e_write_mem_i  = wm;
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] ctl);
        check({tag, "_ctl"}, 32'({m_write_reg_o, m_mem_to_reg_o, m_write_mem_o}), 32'(ctl));
        check({tag, "_res"}, alu_result_o, m_alu);
        check({tag, "_st"},  write_mem_val_o, m_st);
        check({tag, "_des"}, 32'(m_des_r_o), 32'(m_des));
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic do_single(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] st, input logic [4:0] des,
                             input logic wr, input logic mtr, input logic wm);
        drive(1'b1, op, a, b, st, des, wr, mtr, wm);
        #1;
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        m_alu = ref_op(op, a, b);
        m_st  = st;
        m_des = des;
        check_outputs(tag, {wr, mtr, wm});
    endtask

    task automatic do_bubble(input string tag, input logic [3:0] op);
        drive(1'b0, op, $urandom, $urandom, $urandom, 5'($urandom), 1'b1, 1'b1, 1'b1);
        #1;
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        check_outputs(tag, 3'b000);
    endtask

    task automatic do_multi(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] st, input logic [4:0] des,
                            input logic wr, input logic mtr, input logic wm, input logic scramble);
        int   cycles;
        logic bubbles_ok;
        cycles     = 0;
        bubbles_ok = 1'b1;
        drive(1'b1, op, a, b, st, des, wr, mtr, wm);
        #1;
        while (stall_o === 1'b1 && cycles < 40) begin
            cycles++;
            @(posedge clk);
            #1;
            if ({m_write_reg_o, m_mem_to_reg_o, m_write_mem_o} !== 3'b000 ||
                alu_result_o !== m_alu || m_des_r_o !== m_des)
                bubbles_ok = 1'b0;
            if (scramble)
                drive(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
                      5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            #1;
        end
        check({tag, "_stall_cycles"}, 32'(cycles), 32'd33);
        check({tag, "_bubbles"}, 32'(bubbles_ok), 32'd1);
        @(posedge clk);
        #1;
        m_alu = ref_op(op, a, b);
        m_st  = st;
        m_des = des;
        check_outputs(tag, {wr, mtr, wm});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        rst_n = 1'b0;
        drive(1'b1, 4'd12, 32'd5, 32'd6, 32'd7, 5'd8, 1'b1, 1'b1, 1'b1);
        #12;
        check("reset_stall", 32'(stall_o), 32'd0);
        check_outputs("reset", 3'b000);
        drive(1'b0, 4'd0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_single("add",  4'd0,  32'd7, 32'hFFFF_FFFE, 32'h11, 5'd3, 1'b1, 1'b0, 1'b0);
        do_single("sra",  4'd10, 32'h8000_0000, 32'h24, 32'h22, 5'd4, 1'b1, 1'b0, 1'b0);
        check("sra_value", alu_result_o, 32'hF800_0000);
        do_single("slt",  4'd6,  32'hFFFF_FFFF, 32'd1, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
        do_single("sltu", 4'd7,  32'hFFFF_FFFF, 32'd1, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0);

        do_multi("mul", 4'd12, 32'h12345, 32'h1000, 32'h33, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mul_value", alu_result_o, 32'h1234_5000);
        do_bubble("mul_after", 4'd0);

        do_multi("divu",   4'd13, 32'd100, 32'd7, 32'h1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
        check("divu_value", alu_result_o, 32'd14);
        do_multi("remu",   4'd14, 32'd100, 32'd7, 32'h2, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        check("remu_value", alu_result_o, 32'd2);
        do_multi("divu0",  4'd13, 32'd100, 32'd0, 32'h3, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
        check("divu0_value", alu_result_o, 32'hFFFF_FFFF);
        do_multi("remu0",  4'd14, 32'd100, 32'd0, 32'h4, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
        check("remu0_value", alu_result_o, 32'd100);

        drive(1'b1, 4'd12, 32'd3, 32'd5, 32'h5, 5'd14, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_alu = '0;
        m_st  = '0;
        m_des = '0;
        check("midrst_stall", 32'(stall_o), 32'd0);
        check_outputs("midrst", 3'b000);
        drive(1'b0, 4'd0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_single("rst_add", 4'd0, 32'd1, 32'd1, 32'h6, 5'd1, 1'b1, 1'b0, 1'b0);
        check("rst_add_value", alu_result_o, 32'd2);

        do_multi("b2b_divu", 4'd13, 32'd1000, 32'd9, 32'h7, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        do_single("b2b_store", 4'd0, 32'h40, 32'd4, 32'hAB, 5'd0, 1'b0, 1'b0, 1'b1);
        check("b2b_store_addr", alu_result_o, 32'h44);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (op >= 4'd12 && op <= 4'd14 && $urandom_range(0, 1) == 0)
                b = 32'($urandom_range(0, 300));
            if ($urandom_range(0, 7) == 0)
                do_bubble("rnd_bubble", op);
            else if (op >= 4'd12 && op <= 4'd14)
                do_multi("rnd_multi", op, a, b, $urandom, 5'($urandom), 1'($urandom),
                         1'($urandom), 1'($urandom), 1'($urandom));
            else
                do_single("rnd_single", op, a, b, $urandom, 5'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
